// File: rtl/iter_divider_if.sv
// Request/response bundle for iter_divider: operand handshake, flush, result handshake, busy.
// Both handshakes are valid/ready; flush is an abort strobe from the pipeline.
interface iter_divider_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic             in_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;

   modport master (
      output in_valid, in_signed, dividend, divisor, flush, out_ready,
      input  in_ready, out_valid, quotient, remainder, busy
   );

   modport slave (
      input  in_valid, in_signed, dividend, divisor, flush, out_ready,
      output in_ready, out_valid, quotient, remainder, busy
   );
endinterface

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider, signed/unsigned, BITS_PER_CYCLE quotient bits per iteration.
// Latency N+2 edges from handshake to out_valid; result held in DONE until out_ready; no re-accept in DONE.
module iter_divider #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input logic            clk,
   input logic            reset,
   iter_divider_if.slave  div_if
);
   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int PW = WIDTH + BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_ITER,
      S_FIX,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic              sgn_q, sgn_d;
   logic              q_neg_q, q_neg_d;
   logic              r_neg_q, r_neg_d;
   logic              div0_q, div0_d;
   logic              ovf_q, ovf_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [PW-1:0]     rem_q, rem_d;
   logic [WIDTH-1:0]  quo_q, quo_d;
   logic [WIDTH-1:0]  den_q, den_d;
   logic [WIDTH-1:0]  quotient_q, quotient_d;
   logic [WIDTH-1:0]  remainder_q, remainder_d;

   logic [PW-1:0]     step_rem;
   logic [WIDTH-1:0]  step_quo;
   logic [WIDTH-1:0]  a_mag;
   logic [WIDTH-1:0]  b_mag;

   // quo_q starts as the dividend magnitude and fills with quotient bits from the LSB
   always_comb begin
      step_rem = rem_q;
      step_quo = quo_q;
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
         step_rem = {step_rem[PW-2:0], step_quo[WIDTH-1]};
         step_quo = {step_quo[WIDTH-2:0], 1'b0};
         if (step_rem >= {{BITS_PER_CYCLE{1'b0}}, den_q}) begin
            step_rem    = step_rem - {{BITS_PER_CYCLE{1'b0}}, den_q};
            step_quo[0] = 1'b1;
         end
      end
   end

   assign a_mag = (sgn_q && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
   assign b_mag = (sgn_q && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      sgn_d       = sgn_q;
      q_neg_d     = q_neg_q;
      r_neg_d     = r_neg_q;
      div0_d      = div0_q;
      ovf_d       = ovf_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      den_d       = den_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;

      case (state_q)
         S_IDLE: begin
            if (div_if.in_valid && !div_if.flush) begin
               a_d     = div_if.dividend;
               b_d     = div_if.divisor;
               sgn_d   = div_if.in_signed;
               state_d = S_PREP;
            end
         end
         S_PREP: begin
            quo_d   = a_mag;
            den_d   = b_mag;
            rem_d   = '0;
            q_neg_d = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            r_neg_d = sgn_q & a_q[WIDTH-1];
            div0_d  = (b_q == '0);
            ovf_d   = sgn_q && (a_q == MIN_VAL) && (b_q == '1);
            cnt_d   = CW'(N);
            state_d = S_ITER;
         end
         S_ITER: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (div0_q) begin
               quotient_d  = '1;
               remainder_d = a_q;
            end else if (ovf_q) begin
               quotient_d  = MIN_VAL;
               remainder_d = '0;
            end else begin
               quotient_d  = q_neg_q ? (~quo_q + 1'b1) : quo_q;
               remainder_d = r_neg_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            if (div_if.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort wins over every other transition outside IDLE
      if (div_if.flush && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q         <= '0;
         b_q         <= '0;
         sgn_q       <= 1'b0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         div0_q      <= 1'b0;
         ovf_q       <= 1'b0;
         cnt_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         den_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         a_q         <= a_d;
         b_q         <= b_d;
         sgn_q       <= sgn_d;
         q_neg_q     <= q_neg_d;
         r_neg_q     <= r_neg_d;
         div0_q      <= div0_d;
         ovf_q       <= ovf_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         den_q       <= den_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   assign div_if.in_ready  = (state_q == S_IDLE);
   assign div_if.out_valid = (state_q == S_DONE);
   assign div_if.busy      = (state_q != S_IDLE);
   assign div_if.quotient  = quotient_q;
   assign div_if.remainder = remainder_q;

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: a B=1 and a B=2 instance driven by directed and random requests.
// A cycle-level reference (handshake bookkeeping plus native SV division) checks every output.
module tb_iter_divider;
   logic clk;
   logic reset;

   iter_divider_if #(.WIDTH(32)) if0 ();
   iter_divider_if #(.WIDTH(32)) if1 ();

   iter_divider #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut_b1 (
      .clk(clk), .reset(reset), .div_if(if0.slave)
   );
   iter_divider #(.WIDTH(32), .BITS_PER_CYCLE(2)) u_dut_b2 (
      .clk(clk), .reset(reset), .div_if(if1.slave)
   );

   logic [1:0]  in_valid_r, in_signed_r, flush_r, out_ready_r;
   logic [31:0] dvd_r [2];
   logic [31:0] dvs_r [2];
   logic [1:0]  ir_w, ov_w, busy_w;
   logic [31:0] q_w [2];
   logic [31:0] r_w [2];

   assign if0.in_valid  = in_valid_r[0];
   assign if0.in_signed = in_signed_r[0];
   assign if0.dividend  = dvd_r[0];
   assign if0.divisor   = dvs_r[0];
   assign if0.flush     = flush_r[0];
   assign if0.out_ready = out_ready_r[0];
   assign if1.in_valid  = in_valid_r[1];
   assign if1.in_signed = in_signed_r[1];
   assign if1.dividend  = dvd_r[1];
   assign if1.divisor   = dvs_r[1];
   assign if1.flush     = flush_r[1];
   assign if1.out_ready = out_ready_r[1];
   assign ir_w   = {if1.in_ready, if0.in_ready};
   assign ov_w   = {if1.out_valid, if0.out_valid};
   assign busy_w = {if1.busy, if0.busy};
   assign q_w[0] = if0.quotient;
   assign q_w[1] = if1.quotient;
   assign r_w[0] = if0.remainder;
   assign r_w[1] = if1.remainder;

   int n_vec = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference result straight from the arithmetic rules
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic signed [31:0] sa, sb;
      logic [31:0] q, r;
      sa = a;
      sb = b;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (s) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
         end else begin
            q = sa / sb;
            r = sa % sb;
         end
      end else begin
         q = a / b;
         r = a % b;
      end
      return {q, r};
   endfunction

   // Per-unit reference state: one request in flight at most
   logic        inflight [2];
   int          due [2];
   logic [63:0] exp_qr [2];
   int          nc = 0;
   int          n_iter [2] = '{32, 16};

   initial begin
      inflight[0] = 1'b0;
      inflight[1] = 1'b0;
      due[0] = 0;
      due[1] = 0;
      exp_qr[0] = '0;
      exp_qr[1] = '0;
   end

   always @(negedge clk) begin
      logic exp_ov;
      nc++;
      for (int u = 0; u < 2; u++) begin
         if (reset) inflight[u] = 1'b0;
         exp_ov = inflight[u] && (nc >= due[u]);
         chk($sformatf("in_ready[u%0d]", u), 64'(ir_w[u]), 64'(!inflight[u]));
         chk($sformatf("busy[u%0d]", u), 64'(busy_w[u]), 64'(inflight[u]));
         chk($sformatf("out_valid[u%0d]", u), 64'(ov_w[u]), 64'(exp_ov));
         if (exp_ov && ov_w[u]) begin
            chk($sformatf("result[u%0d]", u), {q_w[u], r_w[u]}, exp_qr[u]);
         end
         if (!reset) begin
            if (flush_r[u]) begin
               inflight[u] = 1'b0;
            end else if (!inflight[u] && in_valid_r[u]) begin
               inflight[u] = 1'b1;
               due[u]      = nc + n_iter[u] + 3;
               exp_qr[u]   = ref_div(dvd_r[u], dvs_r[u], in_signed_r[u]);
            end else if (exp_ov && out_ready_r[u]) begin
               inflight[u] = 1'b0;
            end
         end
      end
   end

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic do_op(input int u, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int hold, input int flush_at);
      for (int i = 0; i < 200 && !ir_w[u]; i++) begin
         @(posedge clk); #1;
      end
      if (!ir_w[u]) begin
         chk($sformatf("timeout_in_ready[u%0d]", u), 64'(ir_w[u]), 64'd1);
         return;
      end
      in_valid_r[u]  = 1'b1;
      dvd_r[u]       = a;
      dvs_r[u]       = b;
      in_signed_r[u] = s;
      @(posedge clk); #1;
      in_valid_r[u]  = 1'b0;
      dvd_r[u]       = $urandom;
      dvs_r[u]       = $urandom;
      in_signed_r[u] = ~s;
      if (flush_at >= 0) begin
         repeat (flush_at) @(posedge clk);
         #1;
         flush_r[u] = 1'b1;
         @(posedge clk); #1;
         flush_r[u] = 1'b0;
         return;
      end
      for (int i = 0; i < 60 && !ov_w[u]; i++) begin
         @(posedge clk); #1;
      end
      if (!ov_w[u]) begin
         chk($sformatf("timeout_out_valid[u%0d]", u), 64'(ov_w[u]), 64'd1);
         return;
      end
      repeat (hold) @(posedge clk);
      #1;
      out_ready_r[u] = 1'b1;
      @(posedge clk); #1;
      out_ready_r[u] = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      in_valid_r  = '0;
      in_signed_r = '0;
      flush_r     = '0;
      out_ready_r = '0;
      dvd_r[0] = '0; dvd_r[1] = '0;
      dvs_r[0] = '0; dvs_r[1] = '0;

      chk("model_u_100_7",    ref_div(32'd100, 32'd7, 1'b0),                 {32'd14, 32'd2});
      chk("model_s_m7_2",     ref_div(32'hFFFF_FFF9, 32'd2, 1'b1),           {32'hFFFF_FFFD, 32'hFFFF_FFFF});
      chk("model_s_7_m2",     ref_div(32'd7, 32'hFFFF_FFFE, 1'b1),           {32'hFFFF_FFFD, 32'd1});
      chk("model_s_ovf",      ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1),   {32'h8000_0000, 32'd0});
      chk("model_u_min_ones", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0),   {32'd0, 32'h8000_0000});
      chk("model_div0",       ref_div(32'd5, 32'd0, 1'b1),                   {32'hFFFF_FFFF, 32'd5});

      repeat (2) @(posedge clk);
      #1;
      chk("reset_result_u0", {q_w[0], r_w[0]}, 64'd0);
      chk("reset_result_u1", {q_w[1], r_w[1]}, 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      do_op(0, 32'd100, 32'd7, 1'b0, 0, -1);
      do_op(0, 32'hFFFF_FFF9, 32'd2, 1'b1, 1, -1);
      do_op(0, 32'd7, 32'hFFFF_FFFE, 1'b1, 0, -1);
      do_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, -1);
      do_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, -1);
      do_op(0, 32'd5, 32'd0, 1'b0, 0, -1);
      do_op(0, 32'd5, 32'd0, 1'b1, 2, -1);
      do_op(0, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, -1);
      do_op(0, 32'd12345, 32'd67, 1'b0, 10, -1);
      do_op(0, 32'd999, 32'd4, 1'b0, 0, 10);
      do_op(0, 32'hFFFF_FFFF, 32'd3, 1'b0, 0, -1);

      // Flush and request in the same IDLE cycle: nothing may be accepted
      in_valid_r[0] = 1'b1;
      flush_r[0]    = 1'b1;
      dvd_r[0]      = 32'd9;
      dvs_r[0]      = 32'd3;
      @(posedge clk); #1;
      in_valid_r[0] = 1'b0;
      flush_r[0]    = 1'b0;
      @(posedge clk); #1;

      do_op(1, 32'hFFFF_FFFF, 32'h10, 1'b0, 0, -1);
      do_op(1, 32'hFFFF_FFF9, 32'd2, 1'b1, 3, -1);
      do_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, -1);
      do_op(1, 32'd5, 32'd0, 1'b0, 0, -1);

      for (int i = 0; i < 60; i++) begin
         do_op(i % 2, rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 12)) : -1);
      end

      // Asynchronous reset in the middle of a B=2 iteration
      @(posedge clk); #1;
      in_valid_r[1]  = 1'b1;
      dvd_r[1]       = 32'd1000;
      dvs_r[1]       = 32'd7;
      in_signed_r[1] = 1'b0;
      @(posedge clk); #1;
      in_valid_r[1] = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      chk("async_reset_in_ready", 64'(ir_w[1]), 64'd1);
      chk("async_reset_out_valid", 64'(ov_w[1]), 64'd0);
      chk("async_reset_busy", 64'(busy_w[1]), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      do_op(1, 32'd1000, 32'd7, 1'b0, 0, -1);
      repeat (3) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
